// File: rtl/ternary_lift.sv
// ternary_lift: lifts 700 packed two-bit mod-3 coefficients to Q_BITS-wide
// mod-q coefficients and streams them over valid/ready, then pads with zeros
// up to N coefficients so the multiplier sees a full polynomial.
// Optional feature macro: TERNARY_LIFT_CHK_EN (flags code 11 as illegal via err).
module ternary_lift #(
  parameter int Q_BITS = 13,
  parameter int N_TERN = 700,
  parameter int N      = 701
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*N_TERN:1]   tern_in,
  output logic [Q_BITS-1:0]   coef_out,
  output logic [9:0]          coef_idx,
  output logic                coef_valid,
  input  logic                coef_ready,
  output logic                done,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_PAD    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [9:0] LAST_TERN = 10'(N_TERN - 1);
  localparam logic [9:0] LAST_ALL  = 10'(N - 1);
  localparam bit         HAS_PAD   = (N > N_TERN);

  state_t              state, state_nxt;
  logic [2*N_TERN:1]   sreg;
  logic [9:0]          idx;
  logic                accept;
  logic                last_beat;
  logic                load;

  // Map one two-bit ternary code to its mod-q representative.
  function automatic logic [Q_BITS-1:0] lift(input logic [1:0] code);
    logic [Q_BITS-1:0] r;
    case (code)
      2'b00:   r = '0;
      2'b01:   r = Q_BITS'(1);
      2'b10:   r = '1;
`ifdef TERNARY_LIFT_CHK_EN
      default: r = '0;   // illegal code lifts to zero
`else
      default: r = '1;   // bit 1 dominates: treated as code 2
`endif
    endcase
    return r;
  endfunction

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs, all derived from registered state.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    coef_valid = 1'b0;
    coef_out   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    last_beat  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        coef_valid = 1'b1;
        busy       = 1'b1;
        coef_out   = lift(sreg[2:1]);
        if (coef_ready && idx == LAST_TERN) begin
          last_beat = !HAS_PAD;
          state_nxt = HAS_PAD ? S_PAD : S_DONE;
        end
      end
      S_PAD: begin
        coef_valid = 1'b1;
        busy       = 1'b1;
        if (coef_ready && idx == LAST_ALL) begin
          last_beat = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept   = coef_valid & coef_ready;
  assign coef_idx = idx;

  // Coefficient shift register and beat counter; both hold while the consumer stalls.
  // NOTE: sreg is a plain register bank (not a RAM), so resetting it is legal and keeps
  // coef_out deterministic straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (load) begin
      sreg <= tern_in;
      idx  <= '0;
    end else if (accept) begin
      if (state == S_STREAM) sreg <= {2'b00, sreg[2*N_TERN:3]};
      // Return to zero after the final beat so idx never passes N-1.
      if (last_beat) idx <= '0;
      else           idx <= idx + 10'd1;
    end
  end

`ifdef TERNARY_LIFT_CHK_EN
  // Sticky illegal-code flag: set on accepting a code-11 beat, cleared by start.
  always_ff @(posedge clk) begin
    if (rst)                                                   err <= 1'b0;
    else if (load)                                             err <= 1'b0;
    else if (accept && state == S_STREAM && sreg[2:1] == 2'b11) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_lift.sv
// tb_ternary_lift: directed self-checking bench for ternary_lift.
// Honours TERNARY_LIFT_CHK_EN for the illegal-code expectations.
module tb_ternary_lift;

  localparam int Q_BITS = 13;
  localparam int N_TERN = 700;
  localparam int N      = 701;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [2*N_TERN:1]   tern_in = '0;
  logic [Q_BITS-1:0]   coef_out;
  logic [9:0]          coef_idx;
  logic                coef_valid;
  logic                coef_ready = 1'b0;
  logic                done;
  logic                busy;
  logic                err;

  logic [2*N_TERN:1]   tv_a, tv_b, tv_c;
  int                  checks = 0;
  int                  failures = 0;

  ternary_lift #(.Q_BITS(Q_BITS), .N_TERN(N_TERN), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tern_in    (tern_in),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-written lift table.
  function automatic logic [Q_BITS-1:0] exp_lift(input logic [1:0] code);
    case (code)
      2'b00:   return 13'h0000;
      2'b01:   return 13'h0001;
      2'b10:   return 13'h1FFF;
`ifdef TERNARY_LIFT_CHK_EN
      default: return 13'h0000;
`else
      default: return 13'h1FFF;
`endif
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {coef_valid, done, busy, err, coef_out, coef_idx}, 0);
  endtask

  // Start a pass with tv and follow it beat by beat.
  //   bp            : ready follows 1,0,0,1 instead of constant 1
  //   abort_at      : assert rst when this index is on the bus (-1 = never)
  //   restart_at    : pulse start with tv_b while this index is on the bus (-1 = never)
  //   start_in_done : pulse start during the done cycle
  task automatic run_pass(input logic [2*N_TERN:1] tv, input bit bp, input int abort_at,
                          input int restart_at, input bit start_in_done);
    int          exp_idx = 0;
    int          cyc = 0;
    bit          exp_err = 1'b0;
    bit          fin = 1'b0;
    bit          restarted = 1'b0;
    bit          prev_hold = 1'b0;
    logic [22:0] prev_bus = '0;
    logic [1:0]  code;
    logic [Q_BITS-1:0] exp_coef;

    tern_in = tv;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    while (!fin) begin
      if (cyc > 4 * N + 20) begin
        check("timeout", 1, 0);
        fin = 1'b1;
      end else if (done) begin
        check("done_count", exp_idx, N);
        if (!bp) check("done_latency", cyc, N);
        check("done_valid", coef_valid, 0);
        check("done_busy", busy, 0);
        check("done_err", err, exp_err);
        coef_ready = 1'b0;
        if (start_in_done) begin
          tern_in = tv_b;
          start   = 1'b1;
        end
        tick();
        start = 1'b0;
        check("post_done", {coef_valid, done, busy}, 0);
        check("post_done_err", err, exp_err);
        tick();
        check("idle_hold", {coef_valid, done, busy}, 0);
        fin = 1'b1;
      end else begin
        if (exp_idx < N_TERN) begin
          code     = tv[2*exp_idx+2 -: 2];
          exp_coef = exp_lift(code);
        end else begin
          code     = 2'b00;
          exp_coef = '0;
        end
        check("valid", coef_valid, 1);
        check("busy", busy, 1);
        check("idx", coef_idx, exp_idx);
        check("coef", coef_out, exp_coef);
        check("err", err, exp_err);
        if (prev_hold) check("hold", {coef_out, coef_idx}, prev_bus);
        if (exp_idx == abort_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          coef_ready = 1'b0;
          check_idle("abort_reset");
          for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("abort_idle");
          end
          fin = 1'b1;
        end else begin
          if (exp_idx == restart_at && !restarted) begin
            tern_in   = tv_b;
            start     = 1'b1;
            restarted = 1'b1;
          end
          coef_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
          prev_hold  = !coef_ready;
          prev_bus   = {coef_out, coef_idx};
          if (coef_ready) begin
`ifdef TERNARY_LIFT_CHK_EN
            if (exp_idx < N_TERN && code == 2'b11) exp_err = 1'b1;
`endif
            exp_idx++;
          end
          tick();
          start = 1'b0;
          cyc++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N_TERN; i++) begin
      tv_a[2*i+2 -: 2] = 2'(i % 3);
      tv_b[2*i+2 -: 2] = 2'((i + 1) % 3);
    end
    tv_c = tv_a;
    tv_c[12:11] = 2'b11;

    // Reset for two cycles, then idle with start low.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_idle("reset_idle");
      tick();
    end

    // Full pass at full rate; start during the done cycle must be ignored.
    run_pass(tv_a, 1'b0, -1, -1, 1'b1);

    // Backpressure with ready pattern 1,0,0,1.
    run_pass(tv_a, 1'b1, -1, -1, 1'b0);

    // Reset mid-stream at beat 300, then a fresh pass with a new vector.
    run_pass(tv_a, 1'b0, 300, -1, 1'b0);
    run_pass(tv_b, 1'b0, -1, -1, 1'b0);

    // Second start at beat 50 with a different vector is ignored.
    run_pass(tv_a, 1'b1, -1, 50, 1'b0);

    // Coefficient 5 carries code 11; the next pass clears err on start.
    run_pass(tv_c, 1'b0, -1, -1, 1'b0);
    run_pass(tv_a, 1'b0, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
